// File: rtl/serv_csr_pkg.sv
// Shared encodings and bit positions for the bit-serial machine-mode CSR block.
package serv_csr_pkg;

  typedef enum logic [1:0] {
    ADDR_MSTATUS = 2'd0,
    ADDR_MIE     = 2'd1,
    ADDR_MIP     = 2'd2,
    ADDR_MCAUSE  = 2'd3
  } csr_addr_e;

  typedef enum logic [1:0] {
    SRC_READ  = 2'd0,
    SRC_WRITE = 2'd1,
    SRC_SET   = 2'd2,
    SRC_CLEAR = 2'd3
  } csr_src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TRAP   = 2'd2
  } csr_state_e;

  localparam int unsigned MIE_BIT   = 3;
  localparam int unsigned MPIE_BIT  = 7;
  localparam int unsigned MTIP_BIT  = 7;
  localparam int unsigned PLAT_BASE = 16;

endpackage

// File: rtl/serv_csr_prio_enc.sv
// Interrupt cause encoder: lowest pending platform source wins, then timer, else 0.
module serv_csr_prio_enc
  import serv_csr_pkg::*;
#(
  parameter int unsigned N_IRQ = 4
) (
  input  logic             i_mtip_pend,
  input  logic [N_IRQ-1:0] i_plat_pend,
  output logic [4:0]       o_code
);

  always_comb begin
    o_code = '0;
    if (i_mtip_pend) o_code = 5'(MTIP_BIT);
    for (int k = int'(N_IRQ) - 1; k >= 0; k--) begin
      if (i_plat_pend[k]) o_code = 5'(PLAT_BASE + 32'(k));
    end
  end

endmodule

// File: rtl/serv_csr_mirq.sv
// Bit-serial mstatus/mie/mip/mcause CSR slice with multi-source interrupt
// tracking, serialised CSR access and trap-entry cause shift-out.
module serv_csr_mirq
  import serv_csr_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned N_IRQ = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_csr_addr,
  input  logic [1:0]       i_csr_source,
  input  logic             i_csr_d_sel,
  input  logic [W-1:0]     i_csr_imm,
  input  logic [W-1:0]     i_rs1,
  input  logic             i_trap,
  input  logic             i_trap_irq,
  input  logic [3:0]       i_ecause,
  input  logic             i_mret,
  input  logic             i_mtip,
  input  logic [N_IRQ-1:0] i_irq,
  output logic [W-1:0]     o_q,
  output logic [W-1:0]     o_csr_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_new_irq
);

  localparam int unsigned BEATS = 32 / W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  csr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  csr_addr_e        addr_q, addr_d;
  csr_src_e         src_q, src_d;
  logic             mstat_mie_q, mstat_mie_d;
  logic             mstat_mpie_q, mstat_mpie_d;
  logic             mtie_q, mtie_d;
  logic [N_IRQ-1:0] mie_irq_q, mie_irq_d;
  logic             mtip_q, mtip_d;
  logic [N_IRQ-1:0] mip_irq_q, mip_irq_d;
  logic [31:0]      mcause_q, mcause_d;
  logic             new_irq_q, new_irq_d;

  logic [31:0] reg_img, sel_img, sh;
  logic [W-1:0] q_beat, operand, csr_in;
  logic [4:0]  irq_code;

  serv_csr_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .i_mtip_pend (mtip_q & mtie_q),
    .i_plat_pend (mip_irq_q & mie_irq_q),
    .o_code      (irq_code)
  );

  // Read path: current beat of the selected image, or the fresh mcause while trapping.
  always_comb begin
    unique case (addr_q)
      ADDR_MSTATUS: reg_img = (32'(mstat_mie_q) << MIE_BIT) | (32'(mstat_mpie_q) << MPIE_BIT);
      ADDR_MIE:     reg_img = (32'(mtie_q) << MTIP_BIT) | (32'(mie_irq_q) << PLAT_BASE);
      ADDR_MIP:     reg_img = (32'(mtip_q) << MTIP_BIT) | (32'(mip_irq_q) << PLAT_BASE);
      default:      reg_img = mcause_q;
    endcase
    sel_img = (state_q == ST_TRAP) ? mcause_q : reg_img;
    sh      = 32'(cnt_q) * W;
    q_beat  = (state_q == ST_IDLE) ? '0 : W'(sel_img >> sh);
    operand = i_csr_d_sel ? i_csr_imm : i_rs1;
    if (state_q != ST_ACCESS) begin
      csr_in = q_beat;
    end else begin
      unique case (src_q)
        SRC_WRITE: csr_in = operand;
        SRC_SET:   csr_in = q_beat | operand;
        SRC_CLEAR: csr_in = q_beat & ~operand;
        default:   csr_in = q_beat;
      endcase
    end
  end

  assign o_q       = q_beat;
  assign o_csr_in  = csr_in;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = (state_q != ST_IDLE) && (cnt_q == LAST);
  assign o_new_irq = new_irq_q;

  // Next-state: FSM sequencing, per-beat field write-back, trap entry and mret.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    src_d        = src_q;
    mstat_mie_d  = mstat_mie_q;
    mstat_mpie_d = mstat_mpie_q;
    mtie_d       = mtie_q;
    mie_irq_d    = mie_irq_q;
    mcause_d     = mcause_q;
    mtip_d       = i_mtip;
    mip_irq_d    = i_irq;

    unique case (state_q)
      ST_IDLE: begin
        if (i_trap) begin
          state_d      = ST_TRAP;
          cnt_d        = '0;
          mcause_d     = {i_trap_irq, 26'd0, i_trap_irq ? irq_code : {1'b0, i_ecause}};
          mstat_mpie_d = mstat_mie_q;
          mstat_mie_d  = 1'b0;
        end else if (i_mret) begin
          mstat_mie_d  = mstat_mpie_q;
          mstat_mpie_d = 1'b1;
        end else if (i_en) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          addr_d  = csr_addr_e'(i_csr_addr);
          src_d   = csr_src_e'(i_csr_source);
        end
      end
      ST_ACCESS, ST_TRAP: begin
        // Each writable bit commits at the edge closing the beat that carries it.
        if (state_q == ST_ACCESS && src_q != SRC_READ) begin
          if (addr_q == ADDR_MSTATUS) begin
            if (32'(cnt_q) == MIE_BIT / W)  mstat_mie_d  = csr_in[MIE_BIT % W];
            if (32'(cnt_q) == MPIE_BIT / W) mstat_mpie_d = csr_in[MPIE_BIT % W];
          end
          if (addr_q == ADDR_MIE) begin
            if (32'(cnt_q) == MTIP_BIT / W) mtie_d = csr_in[MTIP_BIT % W];
            for (int unsigned k = 0; k < N_IRQ; k++) begin
              if (32'(cnt_q) == (PLAT_BASE + k) / W) mie_irq_d[k] = csr_in[(PLAT_BASE + k) % W];
            end
          end
        end
        if (cnt_q == LAST) state_d = ST_IDLE;
        else               cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    new_irq_d = (state_d != ST_TRAP) && mstat_mie_d &&
                ((mtip_d && mtie_d) || (|(mip_irq_d & mie_irq_d)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= ADDR_MSTATUS;
      src_q        <= SRC_READ;
      mstat_mie_q  <= 1'b0;
      mstat_mpie_q <= 1'b0;
      mtie_q       <= 1'b0;
      mie_irq_q    <= '0;
      mtip_q       <= 1'b0;
      mip_irq_q    <= '0;
      mcause_q     <= '0;
      new_irq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      src_q        <= src_d;
      mstat_mie_q  <= mstat_mie_d;
      mstat_mpie_q <= mstat_mpie_d;
      mtie_q       <= mtie_d;
      mie_irq_q    <= mie_irq_d;
      mtip_q       <= mtip_d;
      mip_irq_q    <= mip_irq_d;
      mcause_q     <= mcause_d;
      new_irq_q    <= new_irq_d;
    end
  end

endmodule

// File: tb/tb_serv_csr_mirq.sv
// Directed bench for serv_csr_mirq at W=4, N_IRQ=4 (8 beats per access).
module tb_serv_csr_mirq;

  localparam int unsigned W     = 4;
  localparam int unsigned N_IRQ = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, d_sel = 1'b1, trap = 1'b0, trap_irq = 1'b0, mret = 1'b0, mtip = 1'b0;
  logic [1:0]       addr = '0, src = '0;
  logic [W-1:0]     imm = '0, rs1 = '0;
  logic [3:0]       ecause = '0;
  logic [N_IRQ-1:0] irq = '0;
  logic [W-1:0]     q, csr_in;
  logic             busy, done, new_irq;

  int n_vec = 0;
  int n_err = 0;

  serv_csr_mirq #(.W(W), .N_IRQ(N_IRQ)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_csr_addr(addr), .i_csr_source(src),
    .i_csr_d_sel(d_sel), .i_csr_imm(imm), .i_rs1(rs1), .i_trap(trap),
    .i_trap_irq(trap_irq), .i_ecause(ecause), .i_mret(mret), .i_mtip(mtip),
    .i_irq(irq), .o_q(q), .o_csr_in(csr_in), .o_busy(busy), .o_done(done),
    .o_new_irq(new_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Walks the 8 beats after a start strobe, driving operand beats and gathering o_q/o_csr_in.
  task automatic collect(input logic [31:0] opnd, input bit hold_en,
                         output logic [31:0] rd, output logic [31:0] nv, output int done_beat);
    rd = '0; nv = '0; done_beat = -1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      en   = hold_en && (b < 7);
      trap = 1'b0;
      mret = 1'b0;
      imm  = opnd[b*4 +: 4];
      rs1  = ~opnd[b*4 +: 4];
      #1;
      rd[b*4 +: 4] = q;
      nv[b*4 +: 4] = csr_in;
      if (done && done_beat < 0) done_beat = b;
    end
  endtask

  task automatic csr_op(input logic [1:0] a, input logic [1:0] s, input logic [31:0] opnd,
                        input bit hold_en, output logic [31:0] rd, output logic [31:0] nv,
                        output int done_beat);
    @(negedge clk);
    en = 1'b1; addr = a; src = s; d_sel = 1'b1;
    collect(opnd, hold_en, rd, nv, done_beat);
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] rd);
    logic [31:0] nv;
    int db;
    csr_op(a, 2'd0, 32'd0, 1'b0, rd, nv, db);
  endtask

  task automatic trap_op(input bit is_irq, input logic [3:0] ec, input bit with_mret,
                         output logic [31:0] cause, output int done_beat);
    logic [31:0] nv;
    @(negedge clk);
    trap = 1'b1; trap_irq = is_irq; ecause = ec; mret = with_mret;
    collect(32'd0, 1'b0, cause, nv, done_beat);
    chk("trap_csr_in_eq_q", nv, cause);
  endtask

  logic [31:0] rd, nv;
  int          db;

  initial begin
    // Reset state
    @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_csr_in", 32'(csr_in), 32'd0);
    chk("rst_new_irq", 32'(new_irq), 32'd0);
    rst = 1'b0;

    // WRITE mstatus MIE
    csr_op(2'd0, 2'd1, 32'h0000_0008, 1'b0, rd, nv, db);
    chk("wr_mstatus_old", rd, 32'h0);
    chk("wr_mstatus_new", nv, 32'h8);
    chk("wr_mstatus_done_beat", 32'(db), 32'd7);
    csr_read(2'd0, rd);
    chk("rd_mstatus_mie", rd, 32'h8);

    // WRITE all-ones to mie with i_en held (ignored while busy); only writable bits stick
    csr_op(2'd1, 2'd1, 32'hFFFF_FFFF, 1'b1, rd, nv, db);
    chk("wr_mie_new", nv, 32'hFFFF_FFFF);
    chk("wr_mie_en_ignored_done", 32'(db), 32'd7);
    csr_read(2'd1, rd);
    chk("rd_mie_mask", rd, 32'h000F_0080);

    // CLEAR mie
    csr_op(2'd1, 2'd3, 32'h000A_0080, 1'b0, rd, nv, db);
    chk("clr_mie_old", rd, 32'h000F_0080);
    chk("clr_mie_new", nv, 32'h0005_0000);
    csr_read(2'd1, rd);
    chk("rd_mie_after_clr", rd, 32'h0005_0000);

    // mip and mcause are not writable by access
    csr_op(2'd2, 2'd1, 32'hFFFF_FFFF, 1'b0, rd, nv, db);
    csr_read(2'd2, rd);
    chk("rd_mip_ro", rd, 32'h0);
    csr_op(2'd3, 2'd2, 32'h0000_1234, 1'b0, rd, nv, db);
    csr_read(2'd3, rd);
    chk("rd_mcause_ro", rd, 32'h0);

    // Platform interrupts 0 and 2 pending and enabled
    @(negedge clk);
    irq = 4'b0101;
    #1 chk("new_irq_before_edge", 32'(new_irq), 32'd0);
    @(negedge clk); #1;
    chk("new_irq_raised", 32'(new_irq), 32'd1);
    csr_read(2'd2, rd);
    chk("rd_mip_irq", rd, 32'h0005_0000);

    // Interrupt trap: lowest source (k=0) gives code 16
    trap_op(1'b1, 4'h0, 1'b0, rd, db);
    chk("trap_plat_cause", rd, 32'h8000_0010);
    chk("trap_plat_done_beat", 32'(db), 32'd7);
    chk("new_irq_after_trap", 32'(new_irq), 32'd0);
    csr_read(2'd0, rd);
    chk("mstatus_after_trap", rd, 32'h80);
    csr_read(2'd3, rd);
    chk("rd_mcause_plat", rd, 32'h8000_0010);

    // Timer-only interrupt trap
    @(negedge clk);
    irq = '0; mtip = 1'b1;
    csr_op(2'd1, 2'd2, 32'h0000_0080, 1'b0, rd, nv, db);
    chk("set_mie_new", nv, 32'h0005_0080);
    trap_op(1'b1, 4'h0, 1'b0, rd, db);
    chk("trap_timer_beat0", 32'(rd[3:0]), 32'h7);
    chk("trap_timer_beat7", 32'(rd[31:28]), 32'h8);
    chk("trap_timer_cause", rd, 32'h8000_0007);
    csr_read(2'd0, rd);
    chk("mstatus_after_trap2", rd, 32'h0);

    // Simultaneous trap and mret: trap wins; a following mret restores MIE
    csr_op(2'd0, 2'd1, 32'h0000_0008, 1'b0, rd, nv, db);
    trap_op(1'b0, 4'hB, 1'b1, rd, db);
    chk("exc_cause", rd, 32'h0000_000B);
    csr_read(2'd0, rd);
    chk("mstatus_trap_vs_mret", rd, 32'h80);
    @(negedge clk);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    #1;
    chk("mret_stays_idle", 32'(busy), 32'd0);
    chk("mret_new_irq", 32'(new_irq), 32'd1);
    csr_read(2'd0, rd);
    chk("mstatus_after_mret", rd, 32'h88);

    // Reset during beat 3 of CLEAR mie aborts the access
    @(negedge clk);
    mtip = 1'b0;
    en = 1'b1; addr = 2'd1; src = 2'd3; imm = 4'hF; rs1 = 4'h0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      en = 1'b0;
    end
    #1 chk("abort_busy_beat3", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy_rst", 32'(busy), 32'd0);
    chk("abort_q_rst", 32'(q), 32'd0);
    chk("abort_done_rst", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_idle", 32'(busy), 32'd0);
    csr_read(2'd1, rd);
    chk("abort_mie_zero", rd, 32'h0);
    csr_read(2'd0, rd);
    chk("abort_mstatus_zero", rd, 32'h0);
    csr_read(2'd3, rd);
    chk("abort_mcause_zero", rd, 32'h0);
    chk("abort_new_irq", 32'(new_irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
